// File: rtl/barrel_read_sequencer.sv
// Read-side sequencer for the barrel projection buffer: issues source coordinates,
// tracks the fixed buffer read latency and emits an AXI-Stream video frame.
//   state | meaning
//   IDLE  | waiting for start
//   FILL  | frame started, waiting for the buffer to hold enough rows
//   RUN   | issuing coordinates, one per output pixel
//   DRAIN | last coordinate issued, emptying the read pipeline
//   DONE  | one-cycle frame_done pulse
module barrel_read_sequencer #(
  parameter int OUT_WIDTH  = 1080,
  parameter int OUT_HEIGHT = 960,
  parameter int SRC_WIDTH  = 1080,
  parameter int SRC_HEIGHT = 960,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  input  logic [11:0] S_Coord_X,
  input  logic [11:0] S_Coord_Y,
  input  logic        S_Coord_Valid,
  output logic        S_Coord_Ready,
  output logic [11:0] Math_X,
  output logic [11:0] Math_Y,
  input  logic        Math_Ready,
  output logic        Mem_Out_Ready,
  input  logic [15:0] Mem_Out_Data,
  output logic [15:0] M_AXIS_Data,
  output logic        M_AXIS_Valid,
  input  logic        M_AXIS_Ready,
  output logic        M_AXIS_Last,
  output logic        M_AXIS_User,
  output logic [15:0] Underrun_Count
);

  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;

  // Stage 0 lines up with the Math_X/Math_Y register; the remaining LATENCY
  // stages follow the buffer's own read pipeline, so the last stage matches Mem_Out_Data.
  localparam int NS = LATENCY + 1;
  localparam logic [11:0] X_LAST = 12'(OUT_WIDTH - 1);
  localparam logic [11:0] Y_LAST = 12'(OUT_HEIGHT - 1);
  localparam logic [11:0] SX_MAX = 12'(SRC_WIDTH - 1);
  localparam logic [11:0] SY_MAX = 12'(SRC_HEIGHT - 1);

  state_t state, state_nxt;
  logic [11:0] x, y;
  logic [NS-1:0] stg_valid, stg_last, stg_user, stg_oob;
  logic adv, issue, coord_oob, frame_end_px, drain_done;

  assign adv          = M_AXIS_Ready | ~stg_valid[NS-1];
  assign issue        = adv & S_Coord_Valid & Math_Ready & (state == RUN);
  assign coord_oob    = (S_Coord_X > SX_MAX) | (S_Coord_Y > SY_MAX);
  assign frame_end_px = (x == X_LAST) && (y == Y_LAST);
  assign drain_done   = stg_valid[NS-1] & M_AXIS_Ready & ~(|stg_valid[NS-2:0]);

  assign busy          = (state != IDLE);
  assign frame_done    = (state == DONE);
  assign S_Coord_Ready = issue;
  assign Mem_Out_Ready = adv & (issue | (|stg_valid));
  assign M_AXIS_Valid  = stg_valid[NS-1];
  assign M_AXIS_Last   = stg_last[NS-1];
  assign M_AXIS_User   = stg_user[NS-1];
  assign M_AXIS_Data   = stg_oob[NS-1] ? 16'h0000 : Mem_Out_Data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (Math_Ready) state_nxt = RUN;
      RUN:     if (issue && frame_end_px) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x              <= '0;
      y              <= '0;
      Math_X         <= '0;
      Math_Y         <= '0;
      stg_valid      <= '0;
      stg_last       <= '0;
      stg_user       <= '0;
      stg_oob        <= '0;
      Underrun_Count <= '0;
    end else begin
      if (state == IDLE && start) begin
        x <= '0;
        y <= '0;
      end else if (issue) begin
        if (x == X_LAST) begin
          x <= '0;
          y <= (y == Y_LAST) ? 12'd0 : y + 12'd1;
        end else begin
          x <= x + 12'd1;
        end
      end

      if (issue) begin
        Math_X <= (S_Coord_X > SX_MAX) ? SX_MAX : S_Coord_X;
        Math_Y <= (S_Coord_Y > SY_MAX) ? SY_MAX : S_Coord_Y;
      end

      // Flags freeze with the output under backpressure, keeping them aligned to the buffer.
      if (adv) begin
        stg_valid <= {stg_valid[NS-2:0], issue};
        stg_last  <= {stg_last[NS-2:0],  issue & (x == X_LAST)};
        stg_user  <= {stg_user[NS-2:0],  issue & (x == 12'd0) & (y == 12'd0)};
        stg_oob   <= {stg_oob[NS-2:0],   issue & coord_oob};
      end

      if (state == RUN && !Math_Ready && S_Coord_Valid && Underrun_Count != 16'hFFFF)
        Underrun_Count <= Underrun_Count + 16'd1;
    end
  end

endmodule

// File: tb/tb_barrel_read_sequencer.sv
// Scoreboard bench for barrel_read_sequencer with a small 2-stage buffer model.
module tb_barrel_read_sequencer;
  localparam int W = 4, H = 2, SW = 16, SH = 8, LAT = 2, NPIX = W * H;

  logic        clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic        busy, frame_done;
  logic [11:0] S_Coord_X = '0, S_Coord_Y = '0;
  logic        S_Coord_Valid = 1'b0, S_Coord_Ready;
  logic [11:0] Math_X, Math_Y;
  logic        Math_Ready = 1'b1, Mem_Out_Ready;
  logic [15:0] Mem_Out_Data;
  logic [15:0] M_AXIS_Data;
  logic        M_AXIS_Valid, M_AXIS_Ready = 1'b1, M_AXIS_Last, M_AXIS_User;
  logic [15:0] Underrun_Count;

  barrel_read_sequencer #(
    .OUT_WIDTH(W), .OUT_HEIGHT(H), .SRC_WIDTH(SW), .SRC_HEIGHT(SH), .LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .frame_done(frame_done),
    .S_Coord_X(S_Coord_X), .S_Coord_Y(S_Coord_Y), .S_Coord_Valid(S_Coord_Valid),
    .S_Coord_Ready(S_Coord_Ready), .Math_X(Math_X), .Math_Y(Math_Y),
    .Math_Ready(Math_Ready), .Mem_Out_Ready(Mem_Out_Ready), .Mem_Out_Data(Mem_Out_Data),
    .M_AXIS_Data(M_AXIS_Data), .M_AXIS_Valid(M_AXIS_Valid), .M_AXIS_Ready(M_AXIS_Ready),
    .M_AXIS_Last(M_AXIS_Last), .M_AXIS_User(M_AXIS_User), .Underrun_Count(Underrun_Count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pix(input logic [11:0] px, input logic [11:0] py);
    return 16'h8000 | {1'b0, py[6:0], px[7:0]};
  endfunction

  // buffer model: address register then BRAM read, both gated by Mem_Out_Ready
  logic [11:0] b_ax = '0, b_ay = '0;
  logic [15:0] b_data = '0;
  always @(posedge clk) begin
    if (Mem_Out_Ready) begin
      b_ax   <= Math_X;
      b_ay   <= Math_Y;
      b_data <= pix(b_ax, b_ay);
    end
  end
  assign Mem_Out_Data = b_data;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        user;
  } beat_t;
  beat_t exp_q[$];

  int pidx, beat_cnt, first_acc, first_beat, last_beat, done_cyc;
  logic first_user;
  logic abort = 1'b0;
  logic [11:0] cx [NPIX];
  logic [11:0] cy [NPIX];

  always @(negedge clk) begin
    beat_t e, got;
    if (S_Coord_Valid && S_Coord_Ready) begin
      e.data = (S_Coord_X >= SW || S_Coord_Y >= SH) ? 16'h0000 : pix(S_Coord_X, S_Coord_Y);
      e.last = ((pidx % W) == W - 1);
      e.user = (pidx == 0);
      exp_q.push_back(e);
      if (first_acc < 0) first_acc = cyc;
      pidx++;
    end
    if (M_AXIS_Valid && M_AXIS_Ready) begin
      check_eq("sb_beat_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = '{M_AXIS_Data, M_AXIS_Last, M_AXIS_User};
        check_eq("beat_data", got.data, e.data);
        check_eq("beat_last", got.last, e.last);
        check_eq("beat_user", got.user, e.user);
      end
      if (beat_cnt == 0) begin
        first_beat = cyc;
        first_user = M_AXIS_User;
      end
      beat_cnt++;
      last_beat = cyc;
    end
    if (frame_done) done_cyc = cyc;
  end

  task automatic new_frame();
    pidx = 0; beat_cnt = 0; first_acc = -1; first_beat = -1;
    last_beat = -1; done_cyc = -1; first_user = 1'b0;
    for (int i = 0; i < NPIX; i++) begin
      cx[i] = 12'(i);
      cy[i] = 12'd0;
    end
  endtask

  task automatic start_pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_coords();
    for (int i = 0; i < NPIX && !abort; i++) begin
      int t = 0;
      S_Coord_X = cx[i];
      S_Coord_Y = cy[i];
      S_Coord_Valid = 1'b1;
      do begin
        @(negedge clk);
        t++;
      end while (!S_Coord_Ready && !abort && t < 300);
      if (!abort) check_eq("coord_accepted", S_Coord_Ready, 1);
      @(posedge clk); #1;
    end
    S_Coord_Valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!frame_done && t < 500) begin
      @(negedge clk);
      t++;
    end
    check_eq("frame_done_seen", frame_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_accepts(input int n);
    int c = 0, t = 0;
    while (c < n && t < 300) begin
      @(negedge clk);
      t++;
      if (S_Coord_Valid && S_Coord_Ready) c++;
    end
    check_eq("accept_wait", c, n);
  endtask

  task automatic wait_beats(input int n);
    int c = 0, t = 0;
    while (c < n && t < 300) begin
      @(negedge clk);
      t++;
      if (M_AXIS_Valid && M_AXIS_Ready) c++;
    end
    check_eq("beat_wait", c, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    new_frame();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_coord_ready", S_Coord_Ready, 0);
    check_eq("rst_mem_ready", Mem_Out_Ready, 0);
    check_eq("rst_axis_flags", {M_AXIS_Valid, M_AXIS_Last, M_AXIS_User, frame_done}, 0);
    check_eq("rst_math_xy", {Math_X, Math_Y}, 0);
    check_eq("rst_underrun", Underrun_Count, 0);
    @(posedge clk); #1 reset = 1'b1;

    // basic frame, with a stray start mid-frame
    new_frame();
    fork
      send_coords();
      begin
        start_pulse();
        repeat (6) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    wait_done();
    check_eq("first_beat_latency", first_beat - first_acc, 3);
    check_eq("done_after_last_beat", done_cyc - last_beat, 1);
    check_eq("beat_count", beat_cnt, NPIX);
    check_eq("sb_drained", exp_q.size(), 0);
    ok = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (busy) ok = 1'b0;
    end
    check_eq("idle_after_frame", ok, 1);

    // downstream stall on beat 2
    new_frame();
    fork
      send_coords();
      start_pulse();
      begin
        wait_beats(2);
        @(posedge clk); #1 M_AXIS_Ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_math_x", Math_X, 4);
          check_eq("stall_math_y", Math_Y, 0);
          check_eq("stall_data", M_AXIS_Data, pix(12'd2, 12'd0));
          check_eq("stall_mem_ready", Mem_Out_Ready, 0);
        end
        @(posedge clk); #1 M_AXIS_Ready = 1'b1;
      end
    join
    wait_done();
    check_eq("stall_beat_count", beat_cnt, NPIX);

    // FILL holds while the buffer is not ready
    new_frame();
    Math_Ready = 1'b0;
    fork
      send_coords();
      begin
        start_pulse();
        ok = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (!busy || S_Coord_Ready) ok = 1'b0;
        end
        check_eq("fill_hold", ok, 1);
        check_eq("fill_underrun", Underrun_Count, 0);
        @(posedge clk); #1 Math_Ready = 1'b1;
        @(negedge clk);
        check_eq("fill_exit_no_issue", S_Coord_Ready, 0);
        @(negedge clk);
        check_eq("first_issue_after_fill", S_Coord_Ready, 1);
      end
    join
    wait_done();
    check_eq("fill_beat_count", beat_cnt, NPIX);

    // Math_Ready dropped mid-frame
    new_frame();
    fork
      send_coords();
      start_pulse();
      begin
        wait_accepts(3);
        @(posedge clk); #1 Math_Ready = 1'b0;
        ok = 1'b1;
        repeat (7) begin
          @(negedge clk);
          if (S_Coord_Ready) ok = 1'b0;
        end
        check_eq("no_issue_during_drop", ok, 1);
        @(posedge clk); #1 Math_Ready = 1'b1;
      end
    join
    wait_done();
    check_eq("underrun_count", Underrun_Count, 7);
    check_eq("underrun_beat_count", beat_cnt, NPIX);

    // out-of-range source coordinate
    new_frame();
    cx[5] = 12'(SW);
    cy[5] = 12'd5;
    fork
      send_coords();
      start_pulse();
      begin
        int t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!(S_Coord_Valid && S_Coord_Ready && S_Coord_X == 12'(SW)) && t < 300);
        @(negedge clk);
        check_eq("oob_math_x", Math_X, SW - 1);
        check_eq("oob_math_y", Math_Y, 5);
      end
    join
    wait_done();
    check_eq("oob_beat_count", beat_cnt, NPIX);

    // reset with two pixels in flight
    new_frame();
    fork
      send_coords();
      begin
        start_pulse();
        wait_accepts(2);
        @(posedge clk); #1;
        reset = 1'b0;
        abort = 1'b1;
        #1;
        check_eq("midrst_axis_flags", {M_AXIS_Valid, M_AXIS_Last, M_AXIS_User, frame_done}, 0);
        check_eq("midrst_ready", {S_Coord_Ready, Mem_Out_Ready, busy}, 0);
        check_eq("midrst_math_xy", {Math_X, Math_Y}, 0);
        repeat (2) @(negedge clk);
      end
    join
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    abort = 1'b0;
    new_frame();
    fork
      send_coords();
      start_pulse();
    join
    wait_done();
    check_eq("post_rst_first_user", first_user, 1);
    check_eq("post_rst_beat_count", beat_cnt, NPIX);
    check_eq("post_rst_underrun", Underrun_Count, 0);
    check_eq("post_rst_sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
